// File: rtl/i2s_tx_frame.sv
// Multi-channel I2S/TDM serialiser: one-frame holding buffer, internal bit-clock divider, underrun counting.
// Optional build macro I2S_TX_UNDERRUN_HOLD_EN: when defined, an underrun replays the last loaded frame image.
module i2s_tx_frame #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         frame_start,
    output logic [15:0]                  underrun_cnt
);

    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(FRAME);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME / 2);

    logic [CHANNELS*SAMPLE_W-1:0] buf_reg, buf_next;
    logic                         buf_full_reg, buf_full_next;
    logic [DIV_W-1:0]             div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]             bit_cnt_reg, bit_cnt_next;
    logic [FRAME-1:0]             shreg_reg, shreg_next;
    logic                         bclk_reg, bclk_next;
    logic                         lrclk_reg, lrclk_next;
    logic                         sdata_reg, sdata_next;
    logic                         frame_start_reg, frame_start_next;
    logic [15:0]                  underrun_cnt_reg, underrun_cnt_next;

    logic [FRAME-1:0] buf_image;
    logic [FRAME-1:0] underrun_image;
    logic             xfer;
    logic             fall_evt;
    logic             frame_load;

    // Each slot carries its sample MSB-aligned; channel 0 leads the frame.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
        assign buf_image[FRAME-1-gi*SLOT_W -: SLOT_W] =
            SLOT_W'(buf_reg[(CHANNELS-gi)*SAMPLE_W-1 -: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [FRAME-1:0] hold_reg, hold_next;

    assign underrun_image = hold_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end

    always_comb begin
        hold_next = hold_reg;
        if (frame_load && buf_full_reg) begin
            hold_next = buf_image;
        end
    end
`else
    assign underrun_image = '0;
`endif

    assign xfer       = sample_valid && !buf_full_reg;
    assign fall_evt   = enable && bclk_reg && (div_cnt_reg == DIV_LAST);
    assign frame_load = fall_evt && (bit_cnt_reg == '0);

    always_comb begin
        buf_next          = buf_reg;
        buf_full_next     = buf_full_reg;
        div_cnt_next      = div_cnt_reg;
        bit_cnt_next      = bit_cnt_reg;
        shreg_next        = shreg_reg;
        bclk_next         = bclk_reg;
        lrclk_next        = lrclk_reg;
        sdata_next        = sdata_reg;
        frame_start_next  = 1'b0;
        underrun_cnt_next = underrun_cnt_reg;

        if (xfer) begin
            buf_next      = sample_data;
            buf_full_next = 1'b1;
        end

        if (!enable) begin
            div_cnt_next = '0;
            bit_cnt_next = '0;
            shreg_next   = '0;
            bclk_next    = 1'b0;
            lrclk_next   = 1'b0;
            sdata_next   = 1'b0;
        end else begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next = '0;
                bclk_next    = !bclk_reg;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end

            if (fall_evt) begin
                sdata_next   = shreg_reg[FRAME-1];
                shreg_next   = shreg_reg << 1;
                bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == '0) begin
                    lrclk_next = 1'b0;
                end else if (bit_cnt_reg == BIT_HALF) begin
                    lrclk_next = 1'b1;
                end

                // The load overrides the shift, so the old MSB still leaves first (one-bit delay).
                if (frame_load) begin
                    frame_start_next = 1'b1;
                    if (buf_full_reg) begin
                        shreg_next    = buf_image;
                        buf_full_next = 1'b0;
                    end else begin
                        shreg_next = underrun_image;
                        if (underrun_cnt_reg != 16'hFFFF) begin
                            underrun_cnt_next = underrun_cnt_reg + 16'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_reg          <= '0;
            buf_full_reg     <= 1'b0;
            div_cnt_reg      <= '0;
            bit_cnt_reg      <= '0;
            shreg_reg        <= '0;
            bclk_reg         <= 1'b0;
            lrclk_reg        <= 1'b0;
            sdata_reg        <= 1'b0;
            frame_start_reg  <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            buf_reg          <= buf_next;
            buf_full_reg     <= buf_full_next;
            div_cnt_reg      <= div_cnt_next;
            bit_cnt_reg      <= bit_cnt_next;
            shreg_reg        <= shreg_next;
            bclk_reg         <= bclk_next;
            lrclk_reg        <= lrclk_next;
            sdata_reg        <= sdata_next;
            frame_start_reg  <= frame_start_next;
            underrun_cnt_reg <= underrun_cnt_next;
        end
    end

    assign sample_ready = !buf_full_reg;
    assign bclk         = bclk_reg;
    assign lrclk        = lrclk_reg;
    assign sdata        = sdata_reg;
    assign frame_start  = frame_start_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_tx_frame.sv
// Bench for i2s_tx_frame: stereo and 4-channel TDM instances, frames checked against a bit-image model.
module tb_i2s_tx_frame;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable;
    logic [47:0] data2;
    logic        valid2, ready2, bclk2, lrclk2, sdata2, fs2;
    logic [15:0] ur2;
    logic [95:0] data4;
    logic        valid4, ready4, bclk4, lrclk4, sdata4, fs4;
    logic [15:0] ur4;

    i2s_tx_frame #(.CHANNELS(2), .SAMPLE_W(24), .SLOT_W(32), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_data(data2),
        .sample_valid(valid2), .sample_ready(ready2), .bclk(bclk2), .lrclk(lrclk2),
        .sdata(sdata2), .frame_start(fs2), .underrun_cnt(ur2));

    i2s_tx_frame #(.CHANNELS(4), .SAMPLE_W(24), .SLOT_W(32), .BCLK_DIV(DIV)) dut_tdm (
        .clk(clk), .reset(reset), .enable(enable), .sample_data(data4),
        .sample_valid(valid4), .sample_ready(ready4), .bclk(bclk4), .lrclk(lrclk4),
        .sdata(sdata4), .frame_start(fs4), .underrun_cnt(ur4));

    int sel = 0;
    logic m_bclk, m_lrclk, m_sdata, m_fs, m_ready;
    logic [15:0] m_ur;
    assign m_bclk  = (sel == 1) ? bclk4  : bclk2;
    assign m_lrclk = (sel == 1) ? lrclk4 : lrclk2;
    assign m_sdata = (sel == 1) ? sdata4 : sdata2;
    assign m_fs    = (sel == 1) ? fs4    : fs2;
    assign m_ready = (sel == 1) ? ready4 : ready2;
    assign m_ur    = (sel == 1) ? ur4    : ur2;

    int passed = 0, failed = 0, total = 0;
    int cyc = 0, xfers = 0, xfer_cyc = 0;
    logic [95:0] q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame image: each sample MSB-aligned in a 32-bit slot, channel 0 first.
    function automatic logic [127:0] img(input logic [95:0] d, input int ch);
        logic [127:0] r, s;
        r = '0;
        for (int c = 0; c < ch; c++) begin
            s = (128'(d) >> ((ch - 1 - c) * 24)) & 128'hFFFFFF;
            r = (r << 32) | (s << 8);
        end
        return r;
    endfunction

    task automatic present();
        valid2 = 1'b0;
        valid4 = 1'b0;
        if (q.size() > 0) begin
            if (sel == 1) begin
                data4  = q[0];
                valid4 = 1'b1;
            end else begin
                data2  = q[0][47:0];
                valid2 = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [95:0] f);
        q.push_back(f);
        present();
    endtask

    task automatic tick();
        logic x;
        x = (sel == 1) ? (valid4 && ready4) : (valid2 && ready2);
        @(negedge clk);
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL cycle_budget: observed %0d cycles required below 60000", cyc);
            $fatal(1);
        end
        if (x) begin
            void'(q.pop_front());
            xfers++;
            xfer_cyc = cyc;
        end
        present();
    endtask

    task automatic reset_dut();
        q.delete();
        present();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        xfers = 0;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (!m_fs && n < 3000) begin
            tick();
            n++;
        end
        chk("frame_start_seen", 128'(m_fs), 128'd1);
    endtask

    // Collects the bits leaving on the fall events after a load, plus lrclk after each fall.
    task automatic capture(input int frame, output logic [127:0] word, output logic [127:0] lrw,
                           output int bad_per);
        logic prev, fell;
        int per;
        word = '0;
        bad_per = 0;
        lrw = 128'(m_lrclk);
        prev = m_bclk;
        for (int k = 1; k <= frame; k++) begin
            per = 0;
            fell = 1'b0;
            while (!fell && per < 4 * DIV) begin
                tick();
                per++;
                fell = prev && !m_bclk;
                prev = m_bclk;
            end
            if (!fell || per != 2 * DIV) bad_per++;
            word = {word[126:0], m_sdata};
            if (k < frame) lrw = {lrw[126:0], m_lrclk};
        end
    endtask

    task automatic check_frame(input string tag, input logic [95:0] d, input int ch);
        logic [127:0] w, lrw;
        int bad;
        chk({tag, "_fs"}, 128'(m_fs), 128'd1);
        capture(ch * 32, w, lrw, bad);
        chk({tag, "_data"}, w, img(d, ch));
        chk({tag, "_lrclk"}, lrw, (128'd1 << (ch * 16)) - 128'd1);
        chk({tag, "_bclk_period"}, 128'(bad), 128'd0);
    endtask

    initial begin : main
        logic [95:0] f[4];
        logic [95:0] fa, fb, fx;
        logic [127:0] w, lrw, exp_u;
        logic [3:0] acc;
        int n, bad, fsc;

        data2 = '0;
        data4 = '0;
        valid2 = 1'b0;
        valid4 = 1'b0;

        // Reset and idle
        reset_dut();
        chk("reset_ready", 128'(m_ready), 128'd1);
        chk("reset_underrun", 128'(m_ur), 128'd0);
        acc = '0;
        repeat (20) begin
            tick();
            acc = acc | {m_bclk, m_lrclk, m_sdata, m_fs};
        end
        chk("idle_outputs", 128'(acc), 128'd0);

        // Single frame
        push({48'd0, 24'hA5A5A5, 24'h5A5A5A});
        enable = 1'b1;
        wait_fs(n);
        chk("first_fall_cycles", 128'(n), 128'(2 * DIV));
        chk("single_ur_before", 128'(m_ur), 128'd0);
        check_frame("single", {48'd0, 24'hA5A5A5, 24'h5A5A5A}, 2);
        chk("single_ur_after", 128'(m_ur), 128'd1);

        // Backpressure: second frame waits until the first is loaded
        reset_dut();
        fa = {48'd0, 24'h000001, 24'h000002};
        fb = {48'd0, 24'h000003, 24'h000004};
        push(fa);
        push(fb);
        repeat (6) tick();
        chk("bp_ready_held_low", 128'(m_ready), 128'd0);
        chk("bp_one_accepted", 128'(xfers), 128'd1);
        enable = 1'b1;
        wait_fs(n);
        chk("bp_waiting_until_load", 128'(xfers), 128'd1);
        chk("bp_ready_at_load", 128'(m_ready), 128'd1);
        fsc = cyc;
        chk("bp_ur_first", 128'(m_ur), 128'd0);
        capture(64, w, lrw, bad);
        chk("bp_accept_cycle", 128'(xfer_cyc), 128'(fsc + 1));
        chk("bp_frame_a", w, img(fa, 2));
        chk("bp_ur_second", 128'(m_ur), 128'd0);
        check_frame("bp_frame_b", fb, 2);

        // Random stream of back-to-back frames
        reset_dut();
        for (int i = 0; i < 4; i++) f[i] = {48'd0, 24'($urandom), 24'($urandom)};
        for (int i = 0; i < 4; i++) push(f[i]);
        enable = 1'b1;
        wait_fs(n);
        for (int i = 0; i < 4; i++) begin
            chk("stream_ur", 128'(m_ur), 128'd0);
            check_frame("stream", f[i], 2);
        end

        // Disable mid-frame, then re-enable with a frame accepted while idle
        repeat (300) tick();
        chk("mid_lrclk_high", 128'(m_lrclk), 128'd1);
        enable = 1'b0;
        tick();
        chk("disable_outputs", 128'({m_bclk, m_lrclk, m_sdata}), 128'd0);
        fx = {48'd0, 24'($urandom), 24'($urandom)};
        push(fx);
        tick();
        chk("disable_still_accepts", 128'(m_ready), 128'd0);
        enable = 1'b1;
        wait_fs(n);
        chk("reenable_fall_cycles", 128'(n), 128'(2 * DIV));
        check_frame("reenable", fx, 2);

        // Underrun: one frame then three starved frames
        reset_dut();
        fx = {48'd0, 24'($urandom), 24'($urandom)};
        push(fx);
        enable = 1'b1;
        wait_fs(n);
        check_frame("ur_frame", fx, 2);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        exp_u = img(fx, 2);
`else
        exp_u = '0;
`endif
        for (int k = 1; k <= 3; k++) begin
            chk("ur_count", 128'(m_ur), 128'(k));
            capture(64, w, lrw, bad);
            chk("ur_data", w, exp_u);
        end

        // Reset in the middle of a frame
        reset_dut();
        push({48'd0, 24'($urandom), 24'($urandom)});
        enable = 1'b1;
        wait_fs(n);
        repeat (20 * 2 * DIV - 2) tick();
        reset = 1'b1;
        tick();
        chk("midreset_outputs", 128'({m_bclk, m_lrclk, m_sdata, m_fs}), 128'd0);
        chk("midreset_ur", 128'(m_ur), 128'd0);
        chk("midreset_ready", 128'(m_ready), 128'd1);
        reset = 1'b0;
        enable = 1'b0;
        tick();
        fx = {48'd0, 24'($urandom), 24'($urandom)};
        push(fx);
        tick();
        enable = 1'b1;
        wait_fs(n);
        chk("after_reset_ur", 128'(m_ur), 128'd0);
        check_frame("after_reset", fx, 2);

        // TDM, four channels
        sel = 1;
        reset_dut();
        fx = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
        push({24'h111111, 24'h222222, 24'h333333, 24'h444444});
        push(fx);
        enable = 1'b1;
        wait_fs(n);
        check_frame("tdm_fixed", {24'h111111, 24'h222222, 24'h333333, 24'h444444}, 4);
        chk("tdm_ur", 128'(m_ur), 128'd0);
        check_frame("tdm_random", fx, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2s_tx_frame.md
# i2s_tx_frame

Parametrised multi-channel I2S/TDM audio serialiser that turns parallel PCM frames from the sound core into `ac_bclk` / `ac_lrclk` / `ac_dac_sdata` for the codec. It generalises the fixed stereo 24-bit sample latch in the audio path:
- a one-frame holding buffer with valid/ready handshake;
- configurable channel count, sample width and slot width;
- an internal bit-clock divider;
- underrun accounting.

It sits between the sound core and the codec pins, clocked by the 100 MHz system clock.

## Interface
- `CHANNELS`, default 2: channels per frame; even, ≥2.
- `SAMPLE_W`, default 24: bits per sample.
- `SLOT_W`, default 32: bclk periods per channel slot; ≥`SAMPLE_W`.
- `BCLK_DIV`, default 16: clk cycles per bclk half-period; ≥2.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous reset, active-high.
- `enable` in 1: serialiser run control.
- `sample_data` in `CHANNELS*SAMPLE_W`: one frame. Channel 0 occupies the top `SAMPLE_W` bits.
- `sample_valid` in 1: frame offered.
- `sample_ready` out 1: holding buffer empty.
- `bclk` out 1: serial bit clock.
- `lrclk` out 1: word select.
- `sdata` out 1: serial data, MSB first.
- `frame_start` out 1: one-cycle pulse at each frame load.
- `underrun_cnt` out 16: saturating count of frames loaded with no new data.

## Operation
- **Definitions.**
  - FRAME = `CHANNELS*SLOT_W`.
  - Frame image F = concatenation of the slots. Each slot is its sample MSB-aligned and zero-padded to `SLOT_W` bits.
- **Handshake.**
  - `sample_ready` = !buf_full.
  - Transfer occurs when `sample_valid && sample_ready`; buf_full is set on the following cycle.
  - `sample_data` is ignored when no transfer occurs.
- **Divider.**
  - `div_cnt` counts 0..`BCLK_DIV`-1; `bclk` toggles at the terminal count.
  - A fall event is a terminal count with `bclk`=1.
  - All serial state advances only on fall events.
- **Bit counter.** `i` counts 0..FRAME-1 and wraps.
- **At each fall event:**
  - `sdata` <= shreg MSB.
  - shreg <<= 1.
  - `lrclk` <= 0 when `i`==0; `lrclk` <= 1 when `i`==FRAME/2.
- **Frame load (fall event with `i`==0), applied after `sdata` takes the old MSB:**
  - buf_full=1: shreg <= F(buffer), buf_full cleared.
  - buf_full=0: underrun. `underrun_cnt`++, saturating at 0xFFFF. shreg <= 0.
  - `frame_start` pulses for that cycle in both cases.
- **Resulting order.** I2S one-bit delay: the MSB of channel 0 appears at `i`=1, and the MSB of channel `CHANNELS/2` at `i`=FRAME/2+1.
  - For `CHANNELS`>2: TDM with a 50% duty `lrclk`. Channels 0..C/2-1 are in the low half.
- **Load and transfer in the same cycle.** The buffer is emptied that cycle. `sample_ready` stays 0 for that cycle and rises on the next, so the new frame is accepted one cycle later.
- **`enable`=0.**
  - Next cycle: `bclk`, `lrclk`, `sdata`, `div_cnt`, `i` and shreg are all 0. The buffer keeps its contents and still accepts data.
  - Re-enable: the first fall event is at cycle 2·`BCLK_DIV`; it is a frame load with `i`=0.
- **Reset.** Applies mid-frame with no flush; the partial frame is discarded.

## Timing
- Reset values:
  - `bclk`=0, `lrclk`=0, `sdata`=0, `frame_start`=0, `underrun_cnt`=0.
  - Buffer empty, so `sample_ready`=1 in the first cycle after reset deasserts.
- bclk period = 2·`BCLK_DIV` clk. Frame period = 2·`BCLK_DIV`·FRAME clk. At the defaults: 64 bclk/frame, 48.83 kHz.
- `bclk`, `lrclk`, `sdata` and `frame_start` are all registered. `sdata` and `lrclk` change only on `bclk` falling edges, so they are stable at rising edges.
- Latency from transfer to MSB on `sdata`:
  - minimum 1 bclk after the next frame load;
  - maximum one frame period + 1 bclk.
- `underrun_cnt` updates in the same cycle as `frame_start`.

## Configuration
- Macro: `I2S_TX_UNDERRUN_HOLD_EN`.
  - **Defined:** on underrun, shreg reloads the last successfully loaded frame image, so the previous frame repeats. After reset, with no prior frame, it loads zeros. `underrun_cnt` still increments.
  - **Undefined:** underrun frames are all-zero.
- Handshake and timing are identical in both builds.

## Test plan
All scenarios use `CHANNELS`=2, `SAMPLE_W`=24, `SLOT_W`=32, `BCLK_DIV`=4 unless stated.

- **Reset idle:** reset 3 cycles, then idle with `enable`=0 → `bclk`, `lrclk`, `sdata` stay 0; `sample_ready`=1; `underrun_cnt`=0.
- **Single frame:** with `enable`=1, transfer L=0xA5A5A5, R=0x5A5A5A, then hold `sample_valid`=0.
  - bclk period is 8 clk; `lrclk` is low for 32 bclk and high for 32.
  - `sdata` at `i`=1..24 is 0xA5A5A5 and at `i`=25..32 is 0.
  - `sdata` at `i`=33..56 is 0x5A5A5A.
- **Backpressure:** hold `sample_valid`=1 with frames 0x000001/0x000002 then 0x000003/0x000004.
  - The second frame waits with `sample_ready`=0 until `frame_start`.
  - It is accepted exactly 1 cycle after `frame_start`.
  - Serial order is 1, 2, 3, 4; `underrun_cnt`=0.
- **Underrun:** send one frame, then starve for 3 frames → `underrun_cnt`=3.
  - Macro undefined: `sdata` is all 0.
  - Macro defined: the frame repeats 3 times.
- **TDM:** with `CHANNELS`=4, send 0x111111, 0x222222, 0x333333, 0x444444.
  - `lrclk` is low for 64 bclk.
  - MSBs appear at `i`=1, 33, 65, 97 in channel order.
- **Reset mid-frame:** assert reset at `i`=20.
  - Next cycle: all outputs 0.
  - After release, a new frame transfers and plays intact from `i`=1.
